// File: rtl/nzp_cc_unit.sv
// Condition-code unit: NZP decode/hold register, LIFO save stack for interrupt
// entry and RTI, and a registered branch-taken decision.
module nzp_cc_unit #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int SIGNED_CC = 1
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Load,
  input  logic [WIDTH-1:0]           Result,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic                       BrEval,
  input  logic [2:0]                 BrCond,
  input  logic                       ErrClr,
  output logic [2:0]                 NZP,
  output logic                       BrTaken,
  output logic [$clog2(DEPTH+1)-1:0] StackCount,
  output logic                       StackFull,
  output logic                       StackEmpty,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int CW    = $clog2(DEPTH+1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;

  logic [2:0]    stack [SLOTS];
  logic [2:0]    decoded;
  logic [2:0]    nzp_next;
  logic [CW-1:0] count_next;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          pop_ok;
  logic          do_push;
  logic          do_swap;
  logic          ovf_set;
  logic          unf_set;
  logic          br_next;

  assign StackFull  = (StackCount == CW'(DEPTH));
  assign StackEmpty = (StackCount == '0);
  assign wr_idx     = IW'(StackCount);
  assign top_idx    = IW'(StackCount - CW'(1));

  always_comb begin
    decoded = 3'b001;
    if ((SIGNED_CC != 0) && Result[WIDTH-1])
      decoded = 3'b100;
    else if (Result == '0)
      decoded = 3'b010;
  end

  // A pop on a non-empty stack combined with a push becomes a swap; a pop on an
  // empty stack is void, so any accompanying push proceeds as a plain push.
  always_comb begin
    pop_ok     = Pop & ~StackEmpty;
    do_swap    = Push & pop_ok;
    do_push    = Push & ~pop_ok & ~StackFull;
    ovf_set    = Push & ~pop_ok & StackFull;
    unf_set    = Pop & StackEmpty;
    count_next = StackCount;
    if (do_push)
      count_next = StackCount + CW'(1);
    else if (pop_ok && !Push)
      count_next = StackCount - CW'(1);
    nzp_next = NZP;
    if (pop_ok)
      nzp_next = stack[top_idx];
    else if (Load)
      nzp_next = decoded;
    br_next = BrEval & ((BrCond == 3'b111) | (|(BrCond & NZP)));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      NZP        <= '0;
      BrTaken    <= 1'b0;
      StackCount <= '0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      NZP        <= nzp_next;
      BrTaken    <= br_next;
      StackCount <= count_next;
      Overflow   <= ovf_set | (Overflow & ~ErrClr);
      Underflow  <= unf_set | (Underflow & ~ErrClr);
    end
  end

  // Stack contents need no reset; only StackCount qualifies them.
  always_ff @(posedge Clk) begin
    if (do_push)
      stack[wr_idx] <= NZP;
    else if (do_swap)
      stack[top_idx] <= NZP;
  end

endmodule

// File: tb/tb_nzp_cc_unit.sv
// Directed scoreboard bench for nzp_cc_unit: stimulus queues expected state,
// a monitor compares it against the DUT on the falling edge.
module tb_nzp_cc_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Load, Push, Pop, BrEval, ErrClr;
  logic [15:0] Result;
  logic [2:0]  BrCond;

  logic [2:0]  NZP;
  logic        BrTaken, StackFull, StackEmpty, Overflow, Underflow;
  logic [2:0]  StackCount;

  logic [2:0]  u_nzp;
  logic        u_br, u_full, u_empty, u_ovf, u_unf;
  logic [2:0]  u_cnt;

  always #5 Clk = ~Clk;

  nzp_cc_unit #(.WIDTH(16), .DEPTH(4), .SIGNED_CC(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .Result(Result), .Push(Push),
    .Pop(Pop), .BrEval(BrEval), .BrCond(BrCond), .ErrClr(ErrClr), .NZP(NZP),
    .BrTaken(BrTaken), .StackCount(StackCount), .StackFull(StackFull),
    .StackEmpty(StackEmpty), .Overflow(Overflow), .Underflow(Underflow)
  );

  nzp_cc_unit #(.WIDTH(16), .DEPTH(4), .SIGNED_CC(0)) dut_u (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .Result(Result), .Push(Push),
    .Pop(Pop), .BrEval(BrEval), .BrCond(BrCond), .ErrClr(ErrClr), .NZP(u_nzp),
    .BrTaken(u_br), .StackCount(u_cnt), .StackFull(u_full),
    .StackEmpty(u_empty), .Overflow(u_ovf), .Underflow(u_unf)
  );

  typedef struct packed {
    logic [2:0] nzp;
    logic       br;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
    logic       chk_u;
    logic [2:0] unzp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  sample_req = 1'b0;

  exp_t        e;
  string       nm;
  logic [10:0] got, want;

  always @(negedge Clk or posedge sample_req) begin
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      got  = {NZP, BrTaken, StackCount, StackFull, StackEmpty, Overflow, Underflow};
      want = {e.nzp, e.br, e.cnt, (e.cnt == 3'd4), (e.cnt == 3'd0), e.ovf, e.unf};
      if ((got !== want) || (e.chk_u && (u_nzp !== e.unzp))) begin
        fails++;
        $display("FAIL %s: got nzp=%b br=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b unzp=%b | want nzp=%b br=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b unzp=%b",
                 nm, NZP, BrTaken, StackCount, StackFull, StackEmpty, Overflow, Underflow, u_nzp,
                 e.nzp, e.br, e.cnt, (e.cnt == 3'd4), (e.cnt == 3'd0), e.ovf, e.unf,
                 e.chk_u ? e.unzp : u_nzp);
      end
    end
  end

  task automatic expect_state(input string n, input logic [2:0] x_nzp, input logic x_br,
                              input logic [2:0] x_cnt, input logic x_ovf, input logic x_unf,
                              input logic x_chku, input logic [2:0] x_unzp);
    exp_t x;
    x.nzp = x_nzp; x.br = x_br; x.cnt = x_cnt; x.ovf = x_ovf; x.unf = x_unf;
    x.chk_u = x_chku; x.unzp = x_unzp;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic step(input string n, input logic push, input logic pop, input logic load,
                      input logic [15:0] res, input logic breval, input logic [2:0] cond,
                      input logic clr, input logic [2:0] x_nzp, input logic x_br,
                      input logic [2:0] x_cnt, input logic x_ovf, input logic x_unf,
                      input logic x_chku, input logic [2:0] x_unzp);
    @(negedge Clk);
    Push = push; Pop = pop; Load = load; Result = res;
    BrEval = breval; BrCond = cond; ErrClr = clr;
    @(posedge Clk);
    #1;
    Push = 1'b0; Pop = 1'b0; Load = 1'b0; Result = '0;
    BrEval = 1'b0; BrCond = '0; ErrClr = 1'b0;
    expect_state(n, x_nzp, x_br, x_cnt, x_ovf, x_unf, x_chku, x_unzp);
  endtask

  // Reset is asserted between edges and checked before any clock edge arrives.
  task automatic mid_reset(input string n);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    expect_state(n, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    sample_req = 1'b1;
    #1 sample_req = 1'b0;
    @(negedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    Push = 1'b0; Pop = 1'b0; Load = 1'b0; Result = '0;
    BrEval = 1'b0; BrCond = '0; ErrClr = 1'b0;
    #2;
    expect_state("reset_state", 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    sample_req = 1'b1;
    #1 sample_req = 1'b0;
    @(negedge Clk);
    #1 Reset_n = 1'b1;

    //   name            push pop  load res       brev cond    clr   nzp     br   cnt   ovf  unf  chku unzp
    step("dec_neg",      1'b0,1'b0,1'b1,16'h8000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd0,1'b0,1'b0,1'b1,3'b001);
    step("dec_zero",     1'b0,1'b0,1'b1,16'h0000,1'b0,3'b000,1'b0,3'b010,1'b0,3'd0,1'b0,1'b0,1'b1,3'b010);
    step("dec_pos",      1'b0,1'b0,1'b1,16'h0001,1'b0,3'b000,1'b0,3'b001,1'b0,3'd0,1'b0,1'b0,1'b1,3'b001);
    step("br_p_taken",   1'b0,1'b0,1'b0,16'h0000,1'b1,3'b001,1'b0,3'b001,1'b1,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("br_deassert",  1'b0,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b001,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("br_nz_not",    1'b0,1'b0,1'b0,16'h0000,1'b1,3'b110,1'b0,3'b001,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);
    mid_reset("reset_before_br");
    step("br_111_rst",   1'b0,1'b0,1'b0,16'h0000,1'b1,3'b111,1'b0,3'b000,1'b1,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("br_010_rst",   1'b0,1'b0,1'b0,16'h0000,1'b1,3'b010,1'b0,3'b000,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);

    step("push1",        1'b1,1'b0,1'b1,16'h8000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd1,1'b0,1'b0,1'b0,3'b000);
    step("push2",        1'b1,1'b0,1'b1,16'h0000,1'b0,3'b000,1'b0,3'b010,1'b0,3'd2,1'b0,1'b0,1'b0,3'b000);
    step("push3",        1'b1,1'b0,1'b1,16'h0001,1'b0,3'b000,1'b0,3'b001,1'b0,3'd3,1'b0,1'b0,1'b0,3'b000);
    step("push4_full",   1'b1,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b001,1'b0,3'd4,1'b0,1'b0,1'b0,3'b000);
    step("push5_ovf",    1'b1,1'b0,1'b1,16'h0000,1'b0,3'b000,1'b0,3'b010,1'b0,3'd4,1'b1,1'b0,1'b0,3'b000);
    step("br_000_never", 1'b0,1'b0,1'b0,16'h0000,1'b1,3'b000,1'b0,3'b010,1'b0,3'd4,1'b1,1'b0,1'b0,3'b000);
    step("pop_lifo1",    1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b001,1'b0,3'd3,1'b1,1'b0,1'b0,3'b000);
    step("pop_lifo2",    1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b010,1'b0,3'd2,1'b1,1'b0,1'b0,3'b000);
    step("pop_lifo3",    1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd1,1'b1,1'b0,1'b0,3'b000);
    step("pop_lifo4",    1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b000,1'b0,3'd0,1'b1,1'b0,1'b0,3'b000);
    step("clr_ovf",      1'b0,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b1,3'b000,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);

    step("pop_empty_ld", 1'b0,1'b1,1'b1,16'h0000,1'b0,3'b000,1'b0,3'b010,1'b0,3'd0,1'b0,1'b1,1'b0,3'b000);
    step("clr_unf",      1'b0,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b1,3'b010,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("clr_vs_set",   1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b1,3'b010,1'b0,3'd0,1'b0,1'b1,1'b0,3'b000);
    step("clr_unf2",     1'b0,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b1,3'b010,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);

    step("set_p",        1'b0,1'b0,1'b1,16'h0001,1'b0,3'b000,1'b0,3'b001,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("push_ld_n",    1'b1,1'b0,1'b1,16'h8000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd1,1'b0,1'b0,1'b0,3'b000);
    step("swap",         1'b1,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b001,1'b0,3'd1,1'b0,1'b0,1'b0,3'b000);
    step("pop_swapped",  1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("push_ld_z",    1'b1,1'b0,1'b1,16'h0000,1'b0,3'b000,1'b0,3'b010,1'b0,3'd1,1'b0,1'b0,1'b0,3'b000);
    step("pop_saved_n",  1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);
    step("pushpop_empty",1'b1,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd1,1'b0,1'b1,1'b0,3'b000);
    step("ld_p_after",   1'b0,1'b0,1'b1,16'h0001,1'b0,3'b000,1'b0,3'b001,1'b0,3'd1,1'b0,1'b1,1'b0,3'b000);
    step("pop_pp_entry", 1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd0,1'b0,1'b1,1'b0,3'b000);
    step("clr_unf3",     1'b0,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b1,3'b100,1'b0,3'd0,1'b0,1'b0,1'b0,3'b000);

    step("fill1",        1'b1,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd1,1'b0,1'b0,1'b0,3'b000);
    step("fill2",        1'b1,1'b0,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b100,1'b0,3'd2,1'b0,1'b0,1'b0,3'b000);
    step("fill3_br",     1'b1,1'b0,1'b1,16'h0001,1'b1,3'b111,1'b0,3'b001,1'b1,3'd3,1'b0,1'b0,1'b0,3'b000);
    mid_reset("async_reset");
    step("pop_after_rst",1'b0,1'b1,1'b0,16'h0000,1'b0,3'b000,1'b0,3'b000,1'b0,3'd0,1'b0,1'b1,1'b0,3'b000);

    repeat (3) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
